vend_core_param: RTL

//  Parametrised vending core: slot count, stock, prices and credit limit are generic.

---
 rtl/vend_core_param.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vend_core_param.sv
// Parametrised vending core: per-slot stock, credit up to a ceiling, vend on select,
// and greedy largest-coin-first change over a ready/valid hopper handshake.

package vend_core_param_pkg;
  // Default price table: slot i costs 125 + 25*i cents, packed at CREDIT_W pitch.
  function automatic logic [511:0] default_prices(input int w);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r = r | (512'(125 + 25 * i) << (i * w));
    return r;
  endfunction
endpackage

module vend_slot #(
  parameter int CREDIT_W = 12,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5,
  parameter logic [CREDIT_W-1:0] PRICE = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dec,
  input  logic                load,
  input  logic [CREDIT_W-1:0] credit,
  output logic                avail,
  output logic                short_o,
  output logic                sold_out
);
  logic [STOCK_W-1:0] stock_q, stock_d;

  always_comb begin
    stock_d = stock_q;
    if (load) stock_d = STOCK_W'(INIT_STOCK);
    else if (dec && stock_q != '0) stock_d = stock_q - STOCK_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stock_q <= STOCK_W'(INIT_STOCK);
    else     stock_q <= stock_d;
  end

  assign sold_out = (stock_q == '0);
  assign avail    = !sold_out && (credit >= PRICE);
  assign short_o  = !sold_out && (credit < PRICE);
endmodule

module vend_core_param #(
  parameter int NUM_SLOTS = 9,
  parameter int CREDIT_W = 12,
  parameter int MAX_CREDIT = 2000,
  parameter int STOCK_W = 4,
  parameter int INIT_STOCK = 5,
  parameter logic [NUM_SLOTS*CREDIT_W-1:0] PRICES =
    (NUM_SLOTS*CREDIT_W)'(vend_core_param_pkg::default_prices(CREDIT_W)),
  parameter int PRICE_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_SLOTS-1:0] sel,
  input  logic                 coin_valid,
  input  logic [2:0]           coin_type,
  input  logic                 cancel,
  input  logic                 restock,
  input  logic                 chg_ready,
  output logic [CREDIT_W-1:0]  credit,
  output logic [CREDIT_W-1:0]  disp_value,
  output logic [NUM_SLOTS-1:0] avail,
  output logic [NUM_SLOTS-1:0] short,
  output logic [NUM_SLOTS-1:0] sold_out,
  output logic [NUM_SLOTS-1:0] vend,
  output logic                 coin_reject,
  output logic                 chg_valid,
  output logic [2:0]           chg_coin,
  output logic                 busy
);
  localparam int SEL_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int HOLD_W = $clog2(PRICE_HOLD + 2);

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    slot_q, slot_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [CREDIT_W-1:0] hold_price_q, hold_price_d;

  logic [NUM_SLOTS-1:0][CREDIT_W-1:0] price;
  logic [NUM_SLOTS-1:0] dec;
  logic                 load;
  logic [CREDIT_W:0]    coin_sum;
  logic                 coin_ok;
  logic                 sel_hit;
  logic [SEL_W-1:0]     sel_idx;
  logic [2:0]           big_coin;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [2:0] t);
    case (t)
      3'd0:    coin_value = CREDIT_W'(5);
      3'd1:    coin_value = CREDIT_W'(10);
      3'd2:    coin_value = CREDIT_W'(25);
      3'd3:    coin_value = CREDIT_W'(100);
      3'd4:    coin_value = CREDIT_W'(500);
      default: coin_value = '0;
    endcase
  endfunction

  assign price = PRICES;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    vend_slot #(
      .CREDIT_W(CREDIT_W), .STOCK_W(STOCK_W), .INIT_STOCK(INIT_STOCK),
      .PRICE(PRICES[g*CREDIT_W +: CREDIT_W])
    ) u_slot (
      .clk(clk), .rst(rst), .dec(dec[g]), .load(load), .credit(credit_q),
      .avail(avail[g]), .short_o(short[g]), .sold_out(sold_out[g])
    );
  end

  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (sel[i]) begin
        sel_hit = 1'b1;
        sel_idx = SEL_W'(i);
      end
    // Credit is a multiple of 5, so the 5c fallback always exists.
    big_coin = 3'd0;
    for (int c = 1; c <= 4; c++)
      if (credit_q >= coin_value(3'(c))) big_coin = 3'(c);
    coin_sum = {1'b0, credit_q} + {1'b0, coin_value(coin_type)};
    coin_ok  = (coin_type <= 3'd4) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    slot_d       = slot_q;
    hold_cnt_d   = (hold_cnt_q != '0) ? hold_cnt_q - HOLD_W'(1) : '0;
    hold_price_d = hold_price_q;
    dec          = '0;
    load         = 1'b0;
    vend         = '0;
    coin_reject  = 1'b0;
    chg_valid    = 1'b0;
    chg_coin     = 3'd0;
    if (coin_valid || cancel) hold_cnt_d = '0;
    case (state_q)
      S_IDLE: begin
        if (cancel) begin
          coin_reject = coin_valid;
          if (credit_q != '0) state_d = S_CHANGE;
        end else if (coin_valid) begin
          if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
          else         coin_reject = 1'b1;
        end else if (sel_hit) begin
          if (!sold_out[sel_idx]) begin
            if (credit_q >= price[sel_idx]) begin
              state_d       = S_VEND;
              credit_d      = credit_q - price[sel_idx];
              dec[sel_idx]  = 1'b1;
              slot_d        = sel_idx;
            end else begin
              hold_cnt_d   = HOLD_W'(PRICE_HOLD);
              hold_price_d = price[sel_idx];
            end
          end
        end else if (restock) begin
          load = 1'b1;
        end
      end
      S_VEND: begin
        vend[slot_q] = 1'b1;
        coin_reject  = coin_valid;
        state_d      = (credit_q != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        chg_valid   = 1'b1;
        chg_coin    = big_coin;
        coin_reject = coin_valid;
        if (chg_ready) begin
          credit_d = credit_q - coin_value(big_coin);
          if (credit_d == '0) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      slot_q       <= '0;
      hold_cnt_q   <= '0;
      hold_price_q <= '0;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      slot_q       <= slot_d;
      hold_cnt_q   <= hold_cnt_d;
      hold_price_q <= hold_price_d;
    end
  end

  assign credit     = credit_q;
  assign disp_value = (hold_cnt_q != '0) ? hold_price_q : credit_q;
  assign busy       = (state_q != S_IDLE);
endmodule
